id_decode_stage: RTL and testbench
==================================

# id_decode_stage

Parametrised instruction-decode pipeline stage for the five-stage MIPS core, sitting between the IF/ID boundary and register-file read/hazard logic. Each accepted 32-bit instruction is split into its fields, classified, and given an extended immediate. It then leaves through a valid/ready output register backed by a one-entry skid buffer. The stage supports a synchronous flush for branch/jump redirect and keeps a saturating count of delivered instructions.

## Interface
- DATA_W, 32: width of o_imm; legal 32..64.
- PC_W, 32: width of i_pc/o_pc.
- CNT_W, 16: width of o_decoded_count.
- i_clk  in  1  clock; all state updates on rising edge.
- i_reset_n  in  1  reset; asynchronous, active-low.
- i_valid  in  1  upstream instruction valid.
- o_ready  out  1  stage can accept; equals NOT skid_valid, registered.
- i_instruction  in  32  instruction word.
- i_pc  in  PC_W  PC of instruction.
- i_flush  in  1  synchronous flush; discards all held and incoming instructions.
- o_valid  out  1  decoded output valid.
- i_ready  in  1  downstream accepts.
- o_opcode  out  6  bits [31:26].
- o_RS / o_RT / o_RD  out  5 each  bits [25:21] / [20:16] / [15:11].
- o_shamt  out  5  bits [10:6].
- o_funct  out  6  bits [5:0].
- o_imm  out  DATA_W  extended immediate.
- o_jtarget  out  26  bits [25:0].
- o_pc  out  PC_W  PC carried with instruction.
- o_class  out  3  0=R, 1=I-ALU, 2=LOAD, 3=STORE, 4=BRANCH, 5=JUMP, 7=ILLEGAL.
- o_decoded_count  out  CNT_W  saturating count of output handshakes.

## Operation
- Classification by opcode:
  - 0x00 → R.
  - 0x02, 0x03 → JUMP.
  - 0x04–0x07 → BRANCH.
  - 0x08–0x0F → I-ALU.
  - 0x20–0x25 → LOAD.
  - 0x28, 0x29, 0x2B → STORE.
  - all others → ILLEGAL.
- Immediate:
  - opcode 0x0C/0x0D/0x0E (andi/ori/xori): zero-extend [15:0].
  - opcode 0x0F (lui): {[15:0], 16'h0000}, zero-extended to DATA_W.
  - all other opcodes: sign-extend [15:0] to DATA_W.
  - R and JUMP instructions also get o_imm computed by these rules; consumers ignore it.
- Decode is combinational on the input word. The decoded bundle (all fields + pc + class) is what gets stored.
- Storage: output register (out_valid) and skid register (skid_valid).
  - Accept = i_valid AND o_ready.
  - Output register may load when NOT o_valid OR i_ready.
- Accept with output loadable:
  - If skid holds an entry, skid → output and the new bundle → skid.
  - Otherwise the new bundle → output.
- Accept with output stalled: new bundle → skid; o_ready drops next cycle.
- No accept with output loadable: skid (if valid) → output, skid clears; otherwise o_valid ← 0.
- Flush has priority over everything:
  - Next cycle, o_valid = 0 and skid_valid = 0, so o_ready = 1.
  - An instruction presented in the flush cycle is dropped; o_ready still reads its pre-flush value.
  - Counter increments if a handshake (o_valid AND i_ready) occurred in the flush cycle.
- Counter: +1 per cycle where o_valid AND i_ready; holds at 2^CNT_W−1.
- In-order delivery; no instruction is lost or duplicated except by flush.

## Timing
- Reset (async assert, sync release by system):
  - o_valid = 0, skid empty, o_ready = 1, o_decoded_count = 0.
  - All field outputs, o_imm, o_pc, o_class = 0.
- Latency: instruction accepted at edge N appears on outputs after edge N (1 cycle) when the stage is not stalled.
- Throughput: 1 instruction/cycle with i_ready held high.
- While o_valid = 1 AND i_ready = 0, all outputs stay stable.
- o_ready has no combinational path from i_ready or i_valid.
- Reset mid-stall: both entries discarded immediately, regardless of clock.

## Test plan
- Reset then stream addi $t0,$t1,-4 (0x2128FFFC) with i_ready = 1:
  - next cycle o_valid = 1, o_class = 1, o_RS = 9, o_RT = 8.
  - o_imm = 0xFFFFFFFC (DATA_W = 32); o_decoded_count = 1 a cycle later.
- Field/immediate coverage:
  - ori 0x3508FFFF → o_imm = 0x0000FFFF.
  - lui 0x3C081234 → o_imm = 0x12340000.
  - R-type add 0x01095020 → class 0, RD = 10, funct = 0x20.
  - opcode 0x3F → class 7.
- Back-pressure: stream 4 instructions, hold i_ready = 0 for 3 cycles.
  - o_ready falls after the 2nd acceptance; outputs held stable during the stall.
  - After release, all 4 are delivered in order, 1 per cycle.
- Flush while output and skid are both full, with i_valid = 1 in the same cycle:
  - next cycle o_valid = 0, o_ready = 1.
  - the flushed and incoming instructions are never seen downstream.
- Counter saturation (CNT_W = 2): 5 handshakes → o_decoded_count = 3.
- Assert i_reset_n = 0 mid-stall between clock edges → outputs immediately return to reset values.

Source files
------------

// File: rtl/id_decode_stage.sv
// rtl/id_decode_stage.sv - MIPS instruction decode stage with skid-buffered valid/ready output
module id_decode_stage #(
    parameter int DATA_W = 32,
    parameter int PC_W   = 32,
    parameter int CNT_W  = 16
) (
    input  logic              i_clk,
    input  logic              i_reset_n,
    input  logic              i_valid,
    output logic              o_ready,
    input  logic [31:0]       i_instruction,
    input  logic [PC_W-1:0]   i_pc,
    input  logic              i_flush,
    output logic              o_valid,
    input  logic              i_ready,
    output logic [5:0]        o_opcode,
    output logic [4:0]        o_RS,
    output logic [4:0]        o_RT,
    output logic [4:0]        o_RD,
    output logic [4:0]        o_shamt,
    output logic [5:0]        o_funct,
    output logic [DATA_W-1:0] o_imm,
    output logic [25:0]       o_jtarget,
    output logic [PC_W-1:0]   o_pc,
    output logic [2:0]        o_class,
    output logic [CNT_W-1:0]  o_decoded_count
);

    typedef struct packed {
        logic [5:0]        opcode;
        logic [4:0]        rs;
        logic [4:0]        rt;
        logic [4:0]        rd;
        logic [4:0]        shamt;
        logic [5:0]        funct;
        logic [DATA_W-1:0] imm;
        logic [25:0]       jtarget;
        logic [PC_W-1:0]   pc;
        logic [2:0]        cls;
    } bundle_t;

    localparam logic [2:0] CLS_R       = 3'd0;
    localparam logic [2:0] CLS_IALU    = 3'd1;
    localparam logic [2:0] CLS_LOAD    = 3'd2;
    localparam logic [2:0] CLS_STORE   = 3'd3;
    localparam logic [2:0] CLS_BRANCH  = 3'd4;
    localparam logic [2:0] CLS_JUMP    = 3'd5;
    localparam logic [2:0] CLS_ILLEGAL = 3'd7;

    bundle_t          dec;
    bundle_t          out_q, out_d;
    bundle_t          skid_q, skid_d;
    logic             out_valid_q, out_valid_d;
    logic             skid_valid_q, skid_valid_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             accept;
    logic             out_load;
    logic             handshake;

    always_comb begin
        dec         = '0;
        dec.opcode  = i_instruction[31:26];
        dec.rs      = i_instruction[25:21];
        dec.rt      = i_instruction[20:16];
        dec.rd      = i_instruction[15:11];
        dec.shamt   = i_instruction[10:6];
        dec.funct   = i_instruction[5:0];
        dec.jtarget = i_instruction[25:0];
        dec.pc      = i_pc;
        case (i_instruction[31:26]) inside
            6'h00:                dec.cls = CLS_R;
            6'h02, 6'h03:         dec.cls = CLS_JUMP;
            [6'h04:6'h07]:        dec.cls = CLS_BRANCH;
            [6'h08:6'h0F]:        dec.cls = CLS_IALU;
            [6'h20:6'h25]:        dec.cls = CLS_LOAD;
            6'h28, 6'h29, 6'h2B:  dec.cls = CLS_STORE;
            default:              dec.cls = CLS_ILLEGAL;
        endcase
        // Logical immediates zero-extend, lui shifts up, everything else sign-extends.
        case (i_instruction[31:26])
            6'h0C, 6'h0D, 6'h0E: dec.imm = {{(DATA_W-16){1'b0}}, i_instruction[15:0]};
            6'h0F:               dec.imm = DATA_W'({i_instruction[15:0], 16'h0000});
            default:             dec.imm = {{(DATA_W-16){i_instruction[15]}}, i_instruction[15:0]};
        endcase
    end

    assign accept    = i_valid && !skid_valid_q;
    assign out_load  = !out_valid_q || i_ready;
    assign handshake = out_valid_q && i_ready;

    always_comb begin
        out_d        = out_q;
        out_valid_d  = out_valid_q;
        skid_d       = skid_q;
        skid_valid_d = skid_valid_q;
        cnt_d        = cnt_q;
        if (handshake && (cnt_q != {CNT_W{1'b1}})) begin
            cnt_d = cnt_q + CNT_W'(1);
        end
        if (i_flush) begin
            out_valid_d  = 1'b0;
            skid_valid_d = 1'b0;
        end else if (out_load) begin
            // accept implies the skid is empty, so the skid always drains first
            if (skid_valid_q) begin
                out_d        = skid_q;
                out_valid_d  = 1'b1;
                skid_valid_d = 1'b0;
            end else if (accept) begin
                out_d       = dec;
                out_valid_d = 1'b1;
            end else begin
                out_valid_d = 1'b0;
            end
        end else if (accept) begin
            skid_d       = dec;
            skid_valid_d = 1'b1;
        end
    end

    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            out_q        <= '0;
            out_valid_q  <= 1'b0;
            skid_q       <= '0;
            skid_valid_q <= 1'b0;
            cnt_q        <= '0;
        end else begin
            out_q        <= out_d;
            out_valid_q  <= out_valid_d;
            skid_q       <= skid_d;
            skid_valid_q <= skid_valid_d;
            cnt_q        <= cnt_d;
        end
    end

    assign o_ready         = !skid_valid_q;
    assign o_valid         = out_valid_q;
    assign o_opcode        = out_q.opcode;
    assign o_RS            = out_q.rs;
    assign o_RT            = out_q.rt;
    assign o_RD            = out_q.rd;
    assign o_shamt         = out_q.shamt;
    assign o_funct         = out_q.funct;
    assign o_imm           = out_q.imm;
    assign o_jtarget       = out_q.jtarget;
    assign o_pc            = out_q.pc;
    assign o_class         = out_q.cls;
    assign o_decoded_count = cnt_q;

endmodule

// File: tb/tb_id_decode_stage.sv
// tb/tb_id_decode_stage.sv - self-checking bench for id_decode_stage against a queue-based model
module tb_id_decode_stage;

    typedef struct packed {
        logic [5:0]  op;
        logic [4:0]  rs;
        logic [4:0]  rt;
        logic [4:0]  rd;
        logic [4:0]  sh;
        logic [5:0]  fn;
        logic [31:0] imm;
        logic [25:0] jt;
        logic [31:0] pc;
        logic [2:0]  cls;
    } dec_t;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        i_valid = 1'b0;
    logic        i_flush = 1'b0;
    logic        i_ready = 1'b0;
    logic [31:0] i_ins = '0;
    logic [31:0] i_pc = '0;

    logic        o_ready, o_valid;
    logic [5:0]  o_opcode, o_funct;
    logic [4:0]  o_rs, o_rt, o_rd, o_shamt;
    logic [31:0] o_imm, o_pc;
    logic [25:0] o_jt;
    logic [2:0]  o_class;
    logic [15:0] o_cnt;

    logic        s_ready, s_valid;
    logic [5:0]  s_opcode, s_funct;
    logic [4:0]  s_rs, s_rt, s_rd, s_shamt;
    logic [31:0] s_imm, s_pc;
    logic [25:0] s_jt;
    logic [2:0]  s_class;
    logic [1:0]  s_cnt;

    int   n_chk = 0;
    int   n_fail = 0;
    int   n_hs = 0;
    dec_t q[$];

    always #5 clk = ~clk;

    id_decode_stage dut (
        .i_clk(clk), .i_reset_n(rst_n), .i_valid(i_valid), .o_ready(o_ready),
        .i_instruction(i_ins), .i_pc(i_pc), .i_flush(i_flush), .o_valid(o_valid),
        .i_ready(i_ready), .o_opcode(o_opcode), .o_RS(o_rs), .o_RT(o_rt), .o_RD(o_rd),
        .o_shamt(o_shamt), .o_funct(o_funct), .o_imm(o_imm), .o_jtarget(o_jt),
        .o_pc(o_pc), .o_class(o_class), .o_decoded_count(o_cnt)
    );

    id_decode_stage #(.CNT_W(2)) dut_small (
        .i_clk(clk), .i_reset_n(rst_n), .i_valid(i_valid), .o_ready(s_ready),
        .i_instruction(i_ins), .i_pc(i_pc), .i_flush(i_flush), .o_valid(s_valid),
        .i_ready(i_ready), .o_opcode(s_opcode), .o_RS(s_rs), .o_RT(s_rt), .o_RD(s_rd),
        .o_shamt(s_shamt), .o_funct(s_funct), .o_imm(s_imm), .o_jtarget(s_jt),
        .o_pc(s_pc), .o_class(s_class), .o_decoded_count(s_cnt)
    );

    function automatic dec_t model_decode(input logic [31:0] ins, input logic [31:0] pc);
        dec_t d;
        int   op;
        int   lo;
        op    = int'(ins[31:26]);
        lo    = int'(ins[15:0]);
        d.op  = ins[31:26];
        d.rs  = ins[25:21];
        d.rt  = ins[20:16];
        d.rd  = ins[15:11];
        d.sh  = ins[10:6];
        d.fn  = ins[5:0];
        d.jt  = ins[25:0];
        d.pc  = pc;
        if (op == 0)                               d.cls = 3'd0;
        else if (op == 2 || op == 3)               d.cls = 3'd5;
        else if (op >= 4 && op <= 7)               d.cls = 3'd4;
        else if (op >= 8 && op <= 15)              d.cls = 3'd1;
        else if (op >= 32 && op <= 37)             d.cls = 3'd2;
        else if (op == 40 || op == 41 || op == 43) d.cls = 3'd3;
        else                                       d.cls = 3'd7;
        if (op >= 12 && op <= 14)  d.imm = 32'(lo);
        else if (op == 15)         d.imm = 32'(lo * 65536);
        else                       d.imm = 32'((lo >= 32768) ? lo - 65536 : lo);
        return d;
    endfunction

    function automatic dec_t actual();
        dec_t d;
        d.op = o_opcode; d.rs = o_rs; d.rt = o_rt; d.rd = o_rd; d.sh = o_shamt;
        d.fn = o_funct; d.imm = o_imm; d.jt = o_jt; d.pc = o_pc; d.cls = o_class;
        return d;
    endfunction

    function automatic int sat(input int n, input int m);
        return (n > m) ? m : n;
    endfunction

    // Advances one clock from a falling edge to the next, updating the reference queue.
    task automatic step(output bit acc);
        bit   hs;
        dec_t tmp;
        hs  = (q.size() > 0) && i_ready;
        acc = i_valid && (q.size() < 2) && !i_flush;
        @(posedge clk);
        if (i_flush) begin
            q.delete();
        end else begin
            if (hs) tmp = q.pop_front();
            if (acc) q.push_back(model_decode(i_ins, i_pc));
        end
        if (hs) n_hs++;
        @(negedge clk);
    endtask

    task automatic do_reset();
        i_valid = 1'b0; i_flush = 1'b0; i_ready = 1'b0;
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        q.delete();
        n_hs = 0;
        @(negedge clk);
    endtask

    task automatic test_reset();
        do_reset();
        n_chk++; if (o_valid !== 1'b0) begin n_fail++; $display("FAIL reset_valid: got %0b expected 0", o_valid); end
        n_chk++; if (o_ready !== 1'b1) begin n_fail++; $display("FAIL reset_ready: got %0b expected 1", o_ready); end
        n_chk++; if (o_cnt !== 16'd0) begin n_fail++; $display("FAIL reset_count: got %0d expected 0", o_cnt); end
        n_chk++; if (s_cnt !== 2'd0) begin n_fail++; $display("FAIL reset_count_small: got %0d expected 0", s_cnt); end
        n_chk++; if (actual() !== dec_t'(0)) begin n_fail++; $display("FAIL reset_fields: got %h expected 0", actual()); end
    endtask

    task automatic test_addi();
        bit acc;
        i_ready = 1'b1; i_valid = 1'b1; i_ins = 32'h2128FFFC; i_pc = 32'h0000_0400;
        step(acc);
        i_valid = 1'b0;
        n_chk++; if (o_valid !== 1'b1) begin n_fail++; $display("FAIL addi_valid: got %0b expected 1", o_valid); end
        n_chk++; if (o_class !== 3'd1) begin n_fail++; $display("FAIL addi_class: got %0d expected 1", o_class); end
        n_chk++; if (o_rs !== 5'd9) begin n_fail++; $display("FAIL addi_rs: got %0d expected 9", o_rs); end
        n_chk++; if (o_rt !== 5'd8) begin n_fail++; $display("FAIL addi_rt: got %0d expected 8", o_rt); end
        n_chk++; if (o_imm !== 32'hFFFFFFFC) begin n_fail++; $display("FAIL addi_imm: got %h expected fffffffc", o_imm); end
        n_chk++; if (o_pc !== 32'h400) begin n_fail++; $display("FAIL addi_pc: got %h expected 400", o_pc); end
        n_chk++; if (o_cnt !== 16'd0) begin n_fail++; $display("FAIL addi_count0: got %0d expected 0", o_cnt); end
        step(acc);
        n_chk++; if (o_cnt !== 16'd1) begin n_fail++; $display("FAIL addi_count1: got %0d expected 1", o_cnt); end
        n_chk++; if (o_valid !== 1'b0) begin n_fail++; $display("FAIL addi_drain: got %0b expected 0", o_valid); end
    endtask

    task automatic test_fields();
        bit          acc;
        logic [31:0] ins [4];
        ins = '{32'h3508FFFF, 32'h3C081234, 32'h01095020, 32'hFC000000};
        i_ready = 1'b1;
        for (int k = 0; k < 4; k++) begin
            i_valid = 1'b1; i_ins = ins[k]; i_pc = 32'h800 + 32'(4 * k);
            step(acc);
            n_chk++; if (o_valid !== 1'b1) begin n_fail++; $display("FAIL fields_valid%0d: got %0b expected 1", k, o_valid); end
            case (k)
                0: begin
                    n_chk++; if (o_imm !== 32'h0000FFFF) begin n_fail++; $display("FAIL ori_imm: got %h expected 0000ffff", o_imm); end
                end
                1: begin
                    n_chk++; if (o_imm !== 32'h12340000) begin n_fail++; $display("FAIL lui_imm: got %h expected 12340000", o_imm); end
                end
                2: begin
                    n_chk++; if (o_class !== 3'd0) begin n_fail++; $display("FAIL add_class: got %0d expected 0", o_class); end
                    n_chk++; if (o_rd !== 5'd10) begin n_fail++; $display("FAIL add_rd: got %0d expected 10", o_rd); end
                    n_chk++; if (o_funct !== 6'h20) begin n_fail++; $display("FAIL add_funct: got %h expected 20", o_funct); end
                end
                default: begin
                    n_chk++; if (o_class !== 3'd7) begin n_fail++; $display("FAIL illegal_class: got %0d expected 7", o_class); end
                end
            endcase
        end
        i_valid = 1'b0;
        step(acc);
    endtask

    task automatic test_backpressure();
        bit          acc;
        int          sent;
        dec_t        snap;
        logic [31:0] bp [4];
        for (int k = 0; k < 4; k++) bp[k] = $urandom;
        i_ready = 1'b0; i_valid = 1'b1;
        for (int k = 0; k < 2; k++) begin
            i_ins = bp[k]; i_pc = 32'h1000 + 32'(4 * k);
            step(acc);
        end
        n_chk++; if (o_ready !== 1'b0) begin n_fail++; $display("FAIL bp_ready_fall: got %0b expected 0", o_ready); end
        n_chk++; if (actual() !== model_decode(bp[0], 32'h1000)) begin n_fail++; $display("FAIL bp_head: got %h expected %h", actual(), model_decode(bp[0], 32'h1000)); end
        snap = actual();
        i_ins = bp[2]; i_pc = 32'h1008;
        step(acc);
        n_chk++; if (actual() !== snap) begin n_fail++; $display("FAIL bp_stable: got %h expected %h", actual(), snap); end
        n_chk++; if (o_ready !== 1'b0) begin n_fail++; $display("FAIL bp_ready_held: got %0b expected 0", o_ready); end
        i_ready = 1'b1;
        sent = 2;
        for (int c = 0; c < 4; c++) begin
            n_chk++; if (o_valid !== 1'b1) begin n_fail++; $display("FAIL bp_deliver_valid%0d: got %0b expected 1", c, o_valid); end
            n_chk++; if (actual() !== model_decode(bp[c], 32'h1000 + 32'(4 * c))) begin
                n_fail++; $display("FAIL bp_order%0d: got %h expected %h", c, actual(), model_decode(bp[c], 32'h1000 + 32'(4 * c)));
            end
            i_valid = (sent < 4);
            if (sent < 4) begin i_ins = bp[sent]; i_pc = 32'h1000 + 32'(4 * sent); end
            step(acc);
            if (acc) sent++;
        end
        i_valid = 1'b0;
        n_chk++; if (o_valid !== 1'b0) begin n_fail++; $display("FAIL bp_empty: got %0b expected 0", o_valid); end
    endtask

    task automatic test_flush();
        bit acc;
        int nb;
        i_ready = 1'b0; i_valid = 1'b1;
        for (int k = 0; k < 2; k++) begin
            i_ins = $urandom; i_pc = 32'h2000 + 32'(4 * k);
            step(acc);
        end
        n_chk++; if (o_ready !== 1'b0) begin n_fail++; $display("FAIL flush_pre_ready: got %0b expected 0", o_ready); end
        i_flush = 1'b1; i_ins = $urandom; i_pc = 32'h2008;
        step(acc);
        i_flush = 1'b0; i_valid = 1'b0;
        n_chk++; if (o_valid !== 1'b0) begin n_fail++; $display("FAIL flush_valid: got %0b expected 0", o_valid); end
        n_chk++; if (o_ready !== 1'b1) begin n_fail++; $display("FAIL flush_ready: got %0b expected 1", o_ready); end
        i_ready = 1'b1;
        for (int c = 0; c < 4; c++) begin
            n_chk++; if (o_valid !== 1'b0) begin n_fail++; $display("FAIL flush_leak%0d: got %0b expected 0", c, o_valid); end
            step(acc);
        end
        i_valid = 1'b1; i_ins = 32'h2128FFFC; i_pc = 32'h3000;
        step(acc);
        nb = n_hs;
        i_flush = 1'b1; i_ins = $urandom;
        step(acc);
        i_flush = 1'b0; i_valid = 1'b0;
        n_chk++; if (o_cnt !== 16'(sat(nb + 1, 65535))) begin n_fail++; $display("FAIL flush_count: got %0d expected %0d", o_cnt, sat(nb + 1, 65535)); end
        n_chk++; if (o_valid !== 1'b0) begin n_fail++; $display("FAIL flush_hs_valid: got %0b expected 0", o_valid); end
    endtask

    task automatic test_saturation();
        bit acc;
        do_reset();
        i_ready = 1'b1; i_valid = 1'b1;
        for (int k = 0; k < 5; k++) begin
            i_ins = $urandom; i_pc = 32'(k);
            step(acc);
        end
        i_valid = 1'b0;
        step(acc);
        n_chk++; if (s_cnt !== 2'd3) begin n_fail++; $display("FAIL sat_small: got %0d expected 3", s_cnt); end
        n_chk++; if (o_cnt !== 16'd5) begin n_fail++; $display("FAIL sat_wide: got %0d expected 5", o_cnt); end
    endtask

    task automatic test_random();
        bit acc;
        int ops [20];
        ops = '{0, 2, 3, 4, 5, 8, 9, 12, 13, 14, 15, 32, 35, 37, 40, 41, 43, 63, 1, 16};
        for (int c = 0; c < 400; c++) begin
            n_chk++; if (o_valid !== (q.size() > 0)) begin n_fail++; $display("FAIL rnd_valid@%0d: got %0b expected %0b", c, o_valid, q.size() > 0); end
            n_chk++; if (o_ready !== (q.size() < 2)) begin n_fail++; $display("FAIL rnd_ready@%0d: got %0b expected %0b", c, o_ready, q.size() < 2); end
            if (q.size() > 0) begin
                n_chk++; if (actual() !== q[0]) begin n_fail++; $display("FAIL rnd_bundle@%0d: got %h expected %h", c, actual(), q[0]); end
            end
            n_chk++; if (o_cnt !== 16'(sat(n_hs, 65535))) begin n_fail++; $display("FAIL rnd_count@%0d: got %0d expected %0d", c, o_cnt, n_hs); end
            n_chk++; if (s_cnt !== 2'(sat(n_hs, 3))) begin n_fail++; $display("FAIL rnd_count_small@%0d: got %0d expected %0d", c, s_cnt, sat(n_hs, 3)); end
            i_valid = ($urandom_range(0, 3) != 0);
            i_ready = ($urandom_range(0, 3) != 0);
            i_flush = ($urandom_range(0, 19) == 0);
            i_ins   = {6'(ops[$urandom_range(0, 19)]), 26'($urandom)};
            i_pc    = $urandom;
            step(acc);
        end
        i_valid = 1'b0; i_flush = 1'b0;
    endtask

    task automatic test_async_reset();
        bit acc;
        do_reset();
        i_ready = 1'b0; i_valid = 1'b1;
        for (int k = 0; k < 2; k++) begin
            i_ins = $urandom; i_pc = 32'h4000 + 32'(4 * k);
            step(acc);
        end
        i_valid = 1'b0;
        #2 rst_n = 1'b0;
        #1;
        n_chk++; if (o_valid !== 1'b0) begin n_fail++; $display("FAIL areset_valid: got %0b expected 0", o_valid); end
        n_chk++; if (o_ready !== 1'b1) begin n_fail++; $display("FAIL areset_ready: got %0b expected 1", o_ready); end
        n_chk++; if (o_cnt !== 16'd0) begin n_fail++; $display("FAIL areset_count: got %0d expected 0", o_cnt); end
        n_chk++; if (actual() !== dec_t'(0)) begin n_fail++; $display("FAIL areset_fields: got %h expected 0", actual()); end
        @(negedge clk);
        rst_n = 1'b1;
        q.delete();
        n_hs = 0;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        test_reset();
        test_addi();
        test_fields();
        test_backpressure();
        test_flush();
        test_saturation();
        test_random();
        test_async_reset();
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
